// File: rtl/seq_mag_comparator.sv
// Digit-serial magnitude comparator with 7485-style cascade inputs and a start/busy/done handshake.
// Optional macro SIGNED_CMP_EN: treat operands as two's complement (top bit of MSB slice inverted).
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ei,
   input  logic             li,
   input  logic             gi,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPARE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] ra, rb;
   logic             rei, rli, rgi;
   logic [IW-1:0]    idx;
   logic [DIGIT-1:0] sa, sb;
   logic             slice_gt, slice_lt;

   always_comb begin
      sa = '0;
      sb = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) begin
            sa = ra[i*DIGIT +: DIGIT];
            sb = rb[i*DIGIT +: DIGIT];
         end
      end
`ifdef SIGNED_CMP_EN
      // Flipping the sign bit of the top slice maps two's complement order onto unsigned order.
      if (idx == IDX_TOP) begin
         sa[DIGIT-1] = ~sa[DIGIT-1];
         sb[DIGIT-1] = ~sb[DIGIT-1];
      end
`endif
      slice_gt = (sa > sb);
      slice_lt = (sa < sb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ra    <= '0;
         rb    <= '0;
         rei   <= 1'b0;
         rli   <= 1'b0;
         rgi   <= 1'b0;
         idx   <= IDX_TOP;
         gt    <= 1'b0;
         lt    <= 1'b0;
         eq    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  rei   <= ei;
                  rli   <= li;
                  rgi   <= gi;
                  idx   <= IDX_TOP;
                  gt    <= 1'b0;
                  lt    <= 1'b0;
                  eq    <= 1'b0;
                  state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (slice_gt) begin
                  gt    <= 1'b1;
                  state <= S_DONE;
               end else if (slice_lt) begin
                  lt    <= 1'b1;
                  state <= S_DONE;
               end else if (idx != '0) begin
                  idx <= idx - 1'b1;
               end else begin
                  // All slices equal: the cascade inputs decide, equal-in has priority.
                  if (rei)      eq <= 1'b1;
                  else if (rgi) gt <= 1'b1;
                  else if (rli) lt <= 1'b1;
                  else          eq <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_COMPARE);
   assign done = (state == S_DONE);

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Parametrised, digit-serial magnitude comparator; successor to the fixed 16-bit hex cascade comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first.
- Terminates early on the first unequal slice.
- Keeps 7485-style cascade inputs, so multi-word compares can be chained.
- Uses a start/busy/done handshake for use in datapath controllers where area matters more than latency.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle. NDIG = WIDTH/DIGIT slices.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a compare. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepted start.
- b  input  WIDTH  operand B. Captured on the accepted start.
- ei  input  1  cascade equal-in. Captured on start.
- li  input  1  cascade less-in. Captured on start.
- gi  input  1  cascade greater-in. Captured on start.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse; result valid.
- gt  output  1  registered A>B.
- lt  output  1  registered A<B.
- eq  output  1  registered A==B.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - busy=done=gt=lt=eq=0.
  - Operand and cascade registers are cleared.
  - Slice index is set to NDIG-1.
- States:
  - IDLE:
    - start=1 latches a, b, ei, li, gi, sets idx=NDIG-1 and goes to COMPARE.
    - start=0 stays in IDLE.
  - COMPARE (busy=1): each cycle compares slice A[idx*DIGIT +: DIGIT] against the same slice of B as unsigned values.
    - Slice A>B: gt=1, lt=0, eq=0; go to DONE.
    - Slice A<B: lt=1, gt=0, eq=0; go to DONE.
    - Slices equal and idx>0: idx decrements; stay in COMPARE.
    - Slices equal and idx==0: result comes from the cascade inputs; go to DONE.
  - Cascade resolution (priority order):
    - ei=1 gives eq=1.
    - Else gi=1 gives gt=1.
    - Else li=1 gives lt=1.
    - Else eq=1.
    - Exactly one of gt/lt/eq is set.
  - DONE: done=1 for exactly one cycle, busy=0; return to IDLE unconditionally.
- Output hold:
  - gt/lt/eq are cleared to 0 when a start is accepted.
  - They stay 0 throughout COMPARE.
  - They are written on the COMPARE-to-DONE transition and then held until the next accepted start or reset.
- Latency:
  - Let k be the position of the first differing slice counted from the MSB (1..NDIG), or k=NDIG if all slices are equal.
  - COMPARE lasts k cycles.
  - done is high in the cycle after k rising edges following the edge that accepted start, i.e. it rises on edge k+1.
- Ignored start: start while in COMPARE or DONE is ignored; no queuing.
- Operand stability: changes on a/b/cascade inputs after acceptance have no effect.
- Reset mid-compare: aborts the compare; no done pulse; outputs cleared.
- NDIG==1: a single COMPARE cycle.

Optional Feature:
- Macro: SIGNED_CMP_EN.
  - Defined: operands are two's complement. On the MSB slice (idx==NDIG-1) only, the top bit of both slices is inverted before comparison. Lower slices compare as unsigned. Timing is unchanged.
  - Undefined: all slices compare as unsigned; no extra logic.

Test Plan:
- WIDTH=16, a=400 (0x0190), b=400, ei=1, li=0, gi=0, start for 1 cycle -> busy for 4 cycles; done on edge 5; eq=1, gt=lt=0.
- a=512 (0x0200), b=400 -> slice 3 equal, slice 2 has 2>1; busy 2 cycles; done on edge 3; gt=1.
- a=200 (0x00C8), b=400 -> slice 2 has 0<1; done on edge 3; lt=1. Then swap to a=400, b=200 -> gt=1.
- a=b=0x1234, ei=0, gi=1, li=0 -> after 4 cycles gt=1. Repeat with gi=0, li=1 -> lt=1. Repeat with all cascade inputs 0 -> eq=1.
- a=0x8000, b=0x0001:
  - Macro off -> gt=1 after 1 compare cycle.
  - With SIGNED_CMP_EN -> lt=1.
- Abort and ignored start:
  - Start a=b=400; assert start again in COMPARE cycle 2 -> ignored, a single done pulse.
  - New compare with a=b=400; assert rst in COMPARE cycle 2 -> busy=gt=lt=eq=done=0 immediately and FSM in IDLE.
  - Next start behaves normally.
